div_issue_ctrl: RTL and testbench
=================================

# div_issue_ctrl

Execute-stage controller that issues RISC-V M-extension divide/remainder operations to the iterative 64-bit `divider` and returns the result to the pipeline. It captures and width-adjusts operands, resolves divide-by-zero and signed-overflow cases locally without starting the divider, and holds `div_ready` for the whole iteration. It stalls the pipeline until a result is available and drops the request cleanly on flush.

## Interface
- `TIMEOUT_CYCLES`, default 96: BUSY cycles allowed before the watchdog fires; must be ≥ 70.
- `clk` in 1: single clock, all state updates on posedge.
- `rst` in 1: synchronous, active-low reset.
- `ex_div_valid` in 1: EX stage presents an instruction this cycle.
- `ex_inst_opcode` in 8: `INST_DIV/DIVU/DIVW/DIVUW/REM/REMU/REMW/REMUW`. Any other value is ignored.
- `ex_rs1_data` in 64: numerator.
- `ex_rs2_data` in 64: denominator.
- `ex_flush` in 1: kill the in-flight operation.
- `div_stall_req` out 1: freeze the pipeline.
- `div_result_valid` out 1: one-cycle result strobe.
- `div_result_data` out 64: final rd value.
- `div_timeout_err` out 1: sticky watchdog flag.
- `div_divisor` out 64: to the divider's `divisor` port, which carries the numerator (rs1).
- `div_dividend` out 64: to the divider's `dividend` port, which carries the denominator (rs2).
- `div_inst_opcode` out 8: registered opcode to the divider.
- `div_ready` out 1: request, held high through iteration.
- `div_rem_data` in 64: divider result.
- `div_finish` in 1: divider done strobe.

## Operation
- States: IDLE, BUSY, RESP.
- **Accept.** In IDLE, when `ex_div_valid` is high, the opcode is a divide-class opcode, and `ex_flush` is low:
  - register opcode and extended operands.
  - compute the special-case flag.
  - go to RESP if special, else go to BUSY.
- **Operand extension** (a = rs1, b = rs2):
  - `DIVW`/`REMW`: sign-extend bits [31:0].
  - `DIVUW`/`REMUW`: zero-extend bits [31:0].
  - 64-bit ops: pass through unchanged.
- **Divide by zero** (extended b == 0):
  - quotient = 64'hFFFF_FFFF_FFFF_FFFF.
  - remainder = extended a.
- **Signed overflow:**
  - DIV/REM: a == 64'h8000_0000_0000_0000 and b == all-ones gives quotient = a, remainder = 0.
  - DIVW/REMW: a[31:0] == 32'h8000_0000 and b[31:0] == 32'hFFFF_FFFF gives quotient = 64'hFFFF_FFFF_8000_0000, remainder = 0.
- **BUSY:**
  - `div_ready` = 1; divider inputs are held constant from registers.
  - on `div_finish` == 1, capture `div_rem_data` and go to RESP.
  - W ops: the captured result is sign-extended from bit 31.
- **RESP:**
  - `div_result_valid` = 1 and `div_ready` = 0 for exactly one cycle, then IDLE.
  - Because RESP holds `div_ready` low, `div_ready` is low for at least one cycle between consecutive requests, which re-zeroes the divider counter.
- **Stall:** `div_stall_req` = (IDLE & accept condition) | BUSY. It is combinational from the IDLE inputs and low in RESP, so the pipeline advances with the result.
- **Watchdog:**
  - a cycle counter clears on entry to BUSY.
  - if it reaches `TIMEOUT_CYCLES` with no `div_finish`, set `div_timeout_err`, go to RESP with result 0.
  - `div_timeout_err` is cleared only by reset.
- `div_finish` is ignored outside BUSY.

## Timing
- Reset (`rst` = 0 at posedge): state IDLE; all outputs 0, including the registered divider-side outputs and the counter.
- **Special case:** accept at cycle N, result valid at N+1. Stall is high only in cycle N.
- **Normal case:**
  - accept at N; `div_ready` rises at N+1.
  - if `div_finish` is high at cycle M, the result is valid at M+1 and stall falls at M+1.
  - against the team divider, M = N+66.
- **Flush:** `ex_flush` high in any state means next state IDLE, `div_ready` = 0 next cycle, no result strobe. Flush wins over a simultaneous `div_finish` or accept. `div_stall_req` is low in the flush cycle.
- Back-to-back accept is allowed in the IDLE cycle right after RESP; `div_ready` low in RESP provides the mandatory gap.
- Reset mid-BUSY drops `div_ready` next cycle with no result.

## Test plan
- **DIV:** rs1 = 100, rs2 = 7, with a behavioral divider model (finish 66 cycles after `div_ready`) → result 14 one cycle after finish; stall high continuously from accept; `div_ready` low in the RESP cycle.
- **REMW:** rs1 = 64'h0000_0001_FFFF_FFF9 (−7 low word), rs2 = 2, model returns 32'hFFFF_FFFF in the low word → result 64'hFFFF_FFFF_FFFF_FFFF (sign-extended); `div_divisor` observed = 64'hFFFF_FFFF_FFFF_FFF9.
- **Divide by zero:** DIVU rs2 = 0 → result all-ones at N+1, `div_ready` never asserted. REMU rs1 = 0x1234, rs2 = 0 → result 0x1234.
- **Overflow:**
  - DIV 64'h8000_0000_0000_0000 / −1 → 64'h8000_0000_0000_0000 at N+1.
  - DIVW 0x8000_0000 / 0xFFFF_FFFF → 64'hFFFF_FFFF_8000_0000.
  - REM in the same case → 0.
- **Flush:** flush asserted 20 cycles into BUSY → `div_ready` 0 next cycle, no `div_result_valid`. A new DIV 9/3 accepted 1 cycle later returns 3.
- **Watchdog and reset:** model never asserts finish → at BUSY cycle 96, `div_timeout_err` = 1, result 0 strobed, error stays 1 until `rst` = 0; all outputs 0 after reset.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// Execute-stage issue controller for M-extension divide/remainder ops.
// Special cases resolve locally; everything else runs on the iterative divider.
`timescale 1ns/1ps
module div_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_valid,
  input  logic [7:0]  ex_inst_opcode,
  input  logic [63:0] ex_rs1_data,
  input  logic [63:0] ex_rs2_data,
  input  logic        ex_flush,
  output logic        div_stall_req,
  output logic        div_result_valid,
  output logic [63:0] div_result_data,
  output logic        div_timeout_err,
  output logic [63:0] div_divisor,
  output logic [63:0] div_dividend,
  output logic [7:0]  div_inst_opcode,
  output logic        div_ready,
  input  logic [63:0] div_rem_data,
  input  logic        div_finish
);

  localparam logic [7:0] INST_DIV   = 8'h40;
  localparam logic [7:0] INST_DIVU  = 8'h41;
  localparam logic [7:0] INST_DIVW  = 8'h42;
  localparam logic [7:0] INST_DIVUW = 8'h43;
  localparam logic [7:0] INST_REM   = 8'h44;
  localparam logic [7:0] INST_REMU  = 8'h45;
  localparam logic [7:0] INST_REMW  = 8'h46;
  localparam logic [7:0] INST_REMUW = 8'h47;

  localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q, state_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [63:0]     a_q, a_d;
  logic [63:0]     b_q, b_d;
  logic            word_q, word_d;
  logic [63:0]     result_q, result_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  logic        is_div_op, is_word, is_signed, is_rem;
  logic [63:0] a_ext, b_ext;
  logic        div_zero, overflow, special;
  logic [63:0] special_res;
  logic        accept;

  always_comb begin
    is_div_op = 1'b1;
    is_word   = 1'b0;
    is_signed = 1'b0;
    is_rem    = 1'b0;
    case (ex_inst_opcode)
      INST_DIV:   is_signed = 1'b1;
      INST_DIVU:  is_signed = 1'b0;
      INST_DIVW:  begin is_word = 1'b1; is_signed = 1'b1; end
      INST_DIVUW: is_word = 1'b1;
      INST_REM:   begin is_rem = 1'b1; is_signed = 1'b1; end
      INST_REMU:  is_rem = 1'b1;
      INST_REMW:  begin is_rem = 1'b1; is_word = 1'b1; is_signed = 1'b1; end
      INST_REMUW: begin is_rem = 1'b1; is_word = 1'b1; end
      default:    is_div_op = 1'b0;
    endcase
  end

  always_comb begin
    a_ext = ex_rs1_data;
    b_ext = ex_rs2_data;
    if (is_word) begin
      if (is_signed) begin
        a_ext = {{32{ex_rs1_data[31]}}, ex_rs1_data[31:0]};
        b_ext = {{32{ex_rs2_data[31]}}, ex_rs2_data[31:0]};
      end else begin
        a_ext = {32'h0, ex_rs1_data[31:0]};
        b_ext = {32'h0, ex_rs2_data[31:0]};
      end
    end
  end

  always_comb begin
    div_zero = (b_ext == 64'h0);
    if (is_word) begin
      overflow = is_signed && (ex_rs1_data[31:0] == 32'h8000_0000) &&
                 (ex_rs2_data[31:0] == 32'hFFFF_FFFF);
    end else begin
      overflow = is_signed && (ex_rs1_data == 64'h8000_0000_0000_0000) &&
                 (ex_rs2_data == 64'hFFFF_FFFF_FFFF_FFFF);
    end
    special = div_zero | overflow;
    // On overflow the quotient equals the extended numerator for both widths.
    if (div_zero) begin
      special_res = is_rem ? a_ext : 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      special_res = is_rem ? 64'h0 : a_ext;
    end
  end

  assign accept = (state_q == StIdle) && ex_div_valid && is_div_op && !ex_flush;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    a_d      = a_q;
    b_d      = b_q;
    word_d   = word_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (ex_flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            opcode_d = ex_inst_opcode;
            a_d      = a_ext;
            b_d      = b_ext;
            word_d   = is_word;
            cnt_d    = '0;
            if (special) begin
              result_d = special_res;
              state_d  = StResp;
            end else begin
              state_d  = StBusy;
            end
          end
        end
        StBusy: begin
          if (div_finish) begin
            result_d = word_q ? {{32{div_rem_data[31]}}, div_rem_data[31:0]} : div_rem_data;
            state_d  = StResp;
          end else if (cnt_q == CntLast) begin
            err_d    = 1'b1;
            result_d = 64'h0;
            state_d  = StResp;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StResp:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      opcode_q <= 8'h0;
      a_q      <= 64'h0;
      b_q      <= 64'h0;
      word_q   <= 1'b0;
      result_q <= 64'h0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      word_q   <= word_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // The divider's port names are swapped relative to their meaning.
  assign div_divisor      = a_q;
  assign div_dividend     = b_q;
  assign div_inst_opcode  = opcode_q;
  assign div_ready        = (state_q == StBusy);
  assign div_result_valid = (state_q == StResp);
  assign div_result_data  = result_q;
  assign div_timeout_err  = err_q;
  assign div_stall_req    = accept | ((state_q == StBusy) & ~ex_flush);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural 66-cycle divider model.
`timescale 1ns/1ps
module tb_div_issue_ctrl;

  localparam logic [7:0] INST_DIV   = 8'h40;
  localparam logic [7:0] INST_DIVU  = 8'h41;
  localparam logic [7:0] INST_DIVW  = 8'h42;
  localparam logic [7:0] INST_DIVUW = 8'h43;
  localparam logic [7:0] INST_REM   = 8'h44;
  localparam logic [7:0] INST_REMU  = 8'h45;
  localparam logic [7:0] INST_REMW  = 8'h46;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_div_valid = 1'b0;
  logic [7:0]  ex_inst_opcode = 8'h0;
  logic [63:0] ex_rs1_data = 64'h0;
  logic [63:0] ex_rs2_data = 64'h0;
  logic        ex_flush = 1'b0;
  logic        div_stall_req, div_result_valid, div_timeout_err, div_ready, div_finish;
  logic [63:0] div_result_data, div_divisor, div_dividend;
  logic [7:0]  div_inst_opcode;

  logic [63:0] model_rem = 64'h0;
  logic        model_en = 1'b1;
  logic        stray_finish = 1'b0;
  int          mcnt = 0;

  int checks = 0;
  int failures = 0;
  int lat;
  bit ok_run;
  bit err_early;

  div_issue_ctrl #(.TIMEOUT_CYCLES(96)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_div_valid     (ex_div_valid),
    .ex_inst_opcode   (ex_inst_opcode),
    .ex_rs1_data      (ex_rs1_data),
    .ex_rs2_data      (ex_rs2_data),
    .ex_flush         (ex_flush),
    .div_stall_req    (div_stall_req),
    .div_result_valid (div_result_valid),
    .div_result_data  (div_result_data),
    .div_timeout_err  (div_timeout_err),
    .div_divisor      (div_divisor),
    .div_dividend     (div_dividend),
    .div_inst_opcode  (div_inst_opcode),
    .div_ready        (div_ready),
    .div_rem_data     (model_rem),
    .div_finish       (div_finish)
  );

  always #5 clk = ~clk;

  // Divider model: finish in the 66th consecutive cycle of div_ready.
  always @(posedge clk) mcnt <= div_ready ? mcnt + 1 : 0;
  assign div_finish = stray_finish | (model_en && div_ready && (mcnt == 65));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Accept in the current cycle, return positioned in the following cycle.
  task automatic issue(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
    ex_div_valid = 1'b1;
    ex_inst_opcode = op;
    ex_rs1_data = a;
    ex_rs2_data = b;
    #1;
    check("stall_accept", div_stall_req, 64'd1);
    nxt();
    ex_div_valid = 1'b0;
    #1;
  endtask

  task automatic wait_result(output int n);
    n = 1;
    ok_run = 1'b1;
    err_early = 1'b0;
    while (!div_result_valid && n < 300) begin
      if (!div_stall_req || !div_ready) ok_run = 1'b0;
      if (div_timeout_err) err_early = 1'b1;
      nxt();
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, div_stall_req, 64'd0);
    check({tag, "_valid"}, div_result_valid, 64'd0);
    check({tag, "_data"}, div_result_data, 64'd0);
    check({tag, "_err"}, div_timeout_err, 64'd0);
    check({tag, "_divisor"}, div_divisor, 64'd0);
    check({tag, "_dividend"}, div_dividend, 64'd0);
    check({tag, "_opcode"}, div_inst_opcode, 64'd0);
    check({tag, "_ready"}, div_ready, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    nxt();
    nxt();
    check_all_zero("reset");
    rst = 1'b1;
    nxt();

    // DIV 100 / 7
    model_rem = 64'd14;
    issue(INST_DIV, 64'd100, 64'd7);
    check("div_ready_rise", div_ready, 64'd1);
    check("div_divisor", div_divisor, 64'd100);
    check("div_dividend", div_dividend, 64'd7);
    check("div_opcode", div_inst_opcode, {56'h0, INST_DIV});
    wait_result(lat);
    check("div_latency", lat, 64'd67);
    check("div_stall_ready_held", ok_run, 64'd1);
    check("div_valid", div_result_valid, 64'd1);
    check("div_data", div_result_data, 64'd14);
    check("div_resp_ready", div_ready, 64'd0);
    check("div_resp_stall", div_stall_req, 64'd0);
    nxt();
    check("div_valid_one_cycle", div_result_valid, 64'd0);

    // REMW -7 % 2, back-to-back in the first IDLE cycle after RESP
    model_rem = 64'h0000_0000_FFFF_FFFF;
    issue(INST_REMW, 64'h0000_0001_FFFF_FFF9, 64'd2);
    check("remw_divisor", div_divisor, 64'hFFFF_FFFF_FFFF_FFF9);
    check("remw_dividend", div_dividend, 64'd2);
    wait_result(lat);
    check("remw_latency", lat, 64'd67);
    check("remw_data", div_result_data, ONES);

    // Divide by zero
    nxt();
    issue(INST_DIVU, 64'd55, 64'd0);
    check("divu0_valid", div_result_valid, 64'd1);
    check("divu0_data", div_result_data, ONES);
    check("divu0_ready", div_ready, 64'd0);
    check("divu0_stall", div_stall_req, 64'd0);
    nxt();
    check("divu0_ready_after", div_ready, 64'd0);
    issue(INST_REMU, 64'h1234, 64'd0);
    check("remu0_valid", div_result_valid, 64'd1);
    check("remu0_data", div_result_data, 64'h1234);
    nxt();
    issue(INST_DIVUW, 64'd5, 64'h0000_0001_0000_0000);
    check("divuw0_valid", div_result_valid, 64'd1);
    check("divuw0_data", div_result_data, ONES);

    // Signed overflow
    nxt();
    issue(INST_DIV, MIN, ONES);
    check("ovf_div_valid", div_result_valid, 64'd1);
    check("ovf_div_data", div_result_data, MIN);
    nxt();
    issue(INST_REM, MIN, ONES);
    check("ovf_rem_valid", div_result_valid, 64'd1);
    check("ovf_rem_data", div_result_data, 64'd0);
    nxt();
    issue(INST_DIVW, 64'h8000_0000, 64'hFFFF_FFFF);
    check("ovf_divw_data", div_result_data, 64'hFFFF_FFFF_8000_0000);
    nxt();
    issue(INST_REMW, 64'h8000_0000, 64'hFFFF_FFFF);
    check("ovf_remw_data", div_result_data, 64'd0);

    // Unsigned with the same operands is not special
    nxt();
    model_rem = MIN;
    issue(INST_REMU, MIN, ONES);
    check("remu_big_ready", div_ready, 64'd1);
    wait_result(lat);
    check("remu_big_latency", lat, 64'd67);
    check("remu_big_data", div_result_data, MIN);

    // Stray finish in IDLE is ignored
    nxt();
    stray_finish = 1'b1;
    #1;
    nxt();
    stray_finish = 1'b0;
    #1;
    check("stray_finish_valid", div_result_valid, 64'd0);
    check("stray_finish_ready", div_ready, 64'd0);

    // Flush beats a simultaneous accept
    ex_flush = 1'b1;
    ex_div_valid = 1'b1;
    ex_inst_opcode = INST_DIV;
    ex_rs1_data = 64'd9;
    ex_rs2_data = 64'd3;
    #1;
    check("flush_accept_stall", div_stall_req, 64'd0);
    nxt();
    ex_flush = 1'b0;
    ex_div_valid = 1'b0;
    #1;
    check("flush_accept_ready", div_ready, 64'd0);
    check("flush_accept_valid", div_result_valid, 64'd0);

    // Flush 20 cycles into BUSY, then DIV 9 / 3 one cycle later
    model_rem = 64'd10;
    issue(INST_DIV, 64'd50, 64'd5);
    repeat (19) nxt();
    check("flush_busy_ready", div_ready, 64'd1);
    ex_flush = 1'b1;
    #1;
    check("flush_cycle_stall", div_stall_req, 64'd0);
    nxt();
    ex_flush = 1'b0;
    #1;
    check("flush_ready_drop", div_ready, 64'd0);
    check("flush_no_valid", div_result_valid, 64'd0);
    model_rem = 64'd3;
    issue(INST_DIV, 64'd9, 64'd3);
    wait_result(lat);
    check("after_flush_latency", lat, 64'd67);
    check("after_flush_data", div_result_data, 64'd3);

    // Watchdog: divider never finishes
    nxt();
    model_en = 1'b0;
    issue(INST_DIV, 64'd1, 64'd1);
    wait_result(lat);
    check("wdog_latency", lat, 64'd97);
    check("wdog_err_not_early", err_early, 64'd0);
    check("wdog_valid", div_result_valid, 64'd1);
    check("wdog_data", div_result_data, 64'd0);
    check("wdog_err", div_timeout_err, 64'd1);
    nxt();
    check("wdog_err_sticky", div_timeout_err, 64'd1);
    model_en = 1'b1;
    issue(INST_DIVU, 64'd1, 64'd0);
    check("wdog_after_data", div_result_data, ONES);
    check("wdog_err_still", div_timeout_err, 64'd1);

    // Reset mid-BUSY clears everything
    nxt();
    issue(INST_DIV, 64'd8, 64'd2);
    repeat (5) nxt();
    rst = 1'b0;
    nxt();
    check_all_zero("rst_busy");
    rst = 1'b1;
    nxt();
    check("post_rst_valid", div_result_valid, 64'd0);
    check("post_rst_ready", div_ready, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
